pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the i_Stall and i_Flush inputs of the PC register and of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Resolves load-use hazards, multi-cycle MDU (mult/div) occupancy, data-memory busy freezes and branch mispredictions, in a fixed priority order.
- Sits beside the decode stage; takes hazard info from the ID, EX and MEM stages.

Parameters:
REG_ADDR_WIDTH, 5, register-specifier width
MDU_LATENCY, 8, total stall cycles issued per MDU op (legal range 1..255)
CNT_WIDTH, 8, MDU countdown counter width

Ports:
i_Clk  in  1  clock, rising edge
i_Reset  in  1  reset; synchronous, active-high; highest priority
i_ID_Rs  in  REG_ADDR_WIDTH  rs of instruction in ID
i_ID_Rt  in  REG_ADDR_WIDTH  rt of instruction in ID
i_ID_Uses_Rt  in  1  ID instruction reads rt
i_EX_MemRead  in  1  EX instruction is a load
i_EX_Rt  in  REG_ADDR_WIDTH  load destination in EX
i_EX_Branch_Valid  in  1  branch resolved in EX this cycle
i_EX_Branch_Taken  in  1  actual outcome
i_EX_Prediction  in  1  prediction carried down the pipe
i_MDU_Start  in  1  MDU op in EX starting
i_Mem_Busy  in  1  data memory not ready; freeze pipe
o_PC_Stall  out  1  hold PC
o_IFID_Stall  out  1  stall IF/ID register
o_IFID_Flush  out  1  flush IF/ID register
o_IDEX_Stall  out  1  stall ID/EX register
o_IDEX_Flush  out  1  flush ID/EX register
o_EXMEM_Stall  out  1  stall EX/MEM register
o_EXMEM_Flush  out  1  flush EX/MEM register
o_PC_Redirect  out  1  load PC with corrected branch target
o_Mispredict_Count  out  32  perf counter (see feature)
o_Stall_Cycles  out  32  perf counter (see feature)

Behaviour:
- Registered state: FSM {S_RUN, S_MDU} plus down-counter mdu_cnt[CNT_WIDTH-1:0]. All outputs are combinational from state and inputs.
- Reset: i_Reset high at a rising edge sets state to S_RUN and mdu_cnt to 0. While i_Reset is high, all control outputs are forced to 0.
- Derived terms:
  - mispredict = i_EX_Branch_Valid & (i_EX_Branch_Taken ^ i_EX_Prediction)
  - loaduse = i_EX_MemRead & (i_EX_Rt != 0) & ((i_EX_Rt == i_ID_Rs) | (i_ID_Uses_Rt & (i_EX_Rt == i_ID_Rt)))
- Priority, highest first:
  1. i_Mem_Busy (any state): assert PC, IFID, IDEX and EXMEM stalls. No flushes, no redirect. FSM and mdu_cnt hold. A pending mispredict persists because EX is frozen, and is acted on in the first non-busy cycle.
  2. S_MDU: assert PC, IFID and IDEX stalls, plus o_EXMEM_Flush (bubble into MEM).
     - mdu_cnt == 0: go to S_RUN next cycle.
     - otherwise: decrement mdu_cnt.
  3. S_RUN & mispredict: assert o_PC_Redirect, o_IFID_Flush and o_IDEX_Flush for one cycle. No stalls. Any loaduse is ignored, since ID holds a wrong-path instruction.
  4. S_RUN & i_MDU_Start: this cycle counts as stall cycle 1; assert the same outputs as S_MDU.
     - MDU_LATENCY > 1: go to S_MDU with mdu_cnt = MDU_LATENCY-2.
     - MDU_LATENCY == 1: stay in S_RUN.
  5. S_RUN & loaduse: assert o_PC_Stall and o_IFID_Stall, plus o_IDEX_Flush (one bubble). Lasts exactly one cycle, because the load then leaves EX.
  6. Otherwise: all outputs 0.
- MDU stall length: exactly MDU_LATENCY consecutive non-busy cycles; Mem_Busy cycles extend it.
- Stall and flush are never asserted together on the same register.
- Reset mid-S_MDU: next cycle is S_RUN with no residual stall.

Optional Feature:
PIPE_CTRL_PERF_EN
- Defined: two 32-bit wrapping counters, cleared by reset.
  - o_Mispredict_Count increments on each cycle where case 3 fires.
  - o_Stall_Cycles increments on every cycle where o_PC_Stall = 1.
- Undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Reset asserted for 2 cycles, mid-MDU (state S_MDU, mdu_cnt = 3) -> all outputs 0 during reset; S_RUN with all outputs 0 on the cycle after release.
- Load-use: EX_MemRead=1, EX_Rt=5, ID_Rs=5 for one cycle -> PC/IFID stall and IDEX flush for exactly 1 cycle. Same stimulus with EX_Rt=0 -> no stall.
- Mispredict: Branch_Valid=1, Taken=1, Prediction=0, with loaduse also true -> Redirect, IFID flush and IDEX flush for 1 cycle; no stalls.
- MDU_LATENCY=8, MDU_Start pulse -> PC/IFID/IDEX stalls and EXMEM flush for exactly 8 cycles, then all 0. Repeat with MDU_LATENCY=1 -> exactly 1 cycle.
- MDU running, Mem_Busy high 3 cycles at stall cycle 4 -> all four stalls during busy; total MDU stall window becomes 11 cycles.
- Mem_Busy=1 with mispredict asserted -> no redirect while busy. Busy drops -> redirect plus flushes in that cycle. With PIPE_CTRL_PERF_EN, o_Mispredict_Count=1 and o_Stall_Cycles equals the busy length.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, MDU occupancy, dmem busy, branch mispredict.
// Latency: all control outputs are combinational from current FSM state and hazard inputs (0 cycles).
// Backpressure: i_Mem_Busy freezes the whole pipe and this FSM; optional perf counters via PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MDU_LATENCY    = 8,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      i_Clk,
  input  logic                      i_Reset,
  input  logic [REG_ADDR_WIDTH-1:0] i_ID_Rs,
  input  logic [REG_ADDR_WIDTH-1:0] i_ID_Rt,
  input  logic                      i_ID_Uses_Rt,
  input  logic                      i_EX_MemRead,
  input  logic [REG_ADDR_WIDTH-1:0] i_EX_Rt,
  input  logic                      i_EX_Branch_Valid,
  input  logic                      i_EX_Branch_Taken,
  input  logic                      i_EX_Prediction,
  input  logic                      i_MDU_Start,
  input  logic                      i_Mem_Busy,
  output logic                      o_PC_Stall,
  output logic                      o_IFID_Stall,
  output logic                      o_IFID_Flush,
  output logic                      o_IDEX_Stall,
  output logic                      o_IDEX_Flush,
  output logic                      o_EXMEM_Stall,
  output logic                      o_EXMEM_Flush,
  output logic                      o_PC_Redirect,
  output logic [31:0]               o_Mispredict_Count,
  output logic [31:0]               o_Stall_Cycles
);

  localparam logic [0:0] S_RUN = 1'b0;
  localparam logic [0:0] S_MDU = 1'b1;

  // The issuing cycle is stall cycle 1, so the counter covers the remaining MDU_LATENCY-1 cycles (cnt..0).
  localparam int                   MDU_INIT_INT = (MDU_LATENCY > 1) ? (MDU_LATENCY - 2) : 0;
  localparam logic [CNT_WIDTH-1:0] MDU_CNT_INIT = CNT_WIDTH'(MDU_INIT_INT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

  logic [0:0]           state_q;
  logic [0:0]           state_nxt;
  logic [CNT_WIDTH-1:0] mdu_cnt_q;
  logic [CNT_WIDTH-1:0] mdu_cnt_nxt;
  logic                 mispredict;
  logic                 loaduse;

  assign mispredict = i_EX_Branch_Valid & (i_EX_Branch_Taken ^ i_EX_Prediction);
  assign loaduse    = i_EX_MemRead & (i_EX_Rt != '0) &
                      ((i_EX_Rt == i_ID_Rs) | (i_ID_Uses_Rt & (i_EX_Rt == i_ID_Rt)));

  // Fixed-priority hazard resolution: busy > MDU occupancy > mispredict > MDU issue > load-use.
  always_comb begin
    o_PC_Stall    = 1'b0;
    o_IFID_Stall  = 1'b0;
    o_IFID_Flush  = 1'b0;
    o_IDEX_Stall  = 1'b0;
    o_IDEX_Flush  = 1'b0;
    o_EXMEM_Stall = 1'b0;
    o_EXMEM_Flush = 1'b0;
    o_PC_Redirect = 1'b0;
    state_nxt     = state_q;
    mdu_cnt_nxt   = mdu_cnt_q;
    if (i_Reset) begin
      state_nxt   = S_RUN;
      mdu_cnt_nxt = '0;
    end else if (i_Mem_Busy) begin
      // Whole pipe frozen; a pending mispredict stays in EX and is handled once busy drops.
      o_PC_Stall    = 1'b1;
      o_IFID_Stall  = 1'b1;
      o_IDEX_Stall  = 1'b1;
      o_EXMEM_Stall = 1'b1;
    end else if (state_q == S_MDU) begin
      o_PC_Stall    = 1'b1;
      o_IFID_Stall  = 1'b1;
      o_IDEX_Stall  = 1'b1;
      o_EXMEM_Flush = 1'b1;
      if (mdu_cnt_q == '0) begin
        state_nxt = S_RUN;
      end else begin
        mdu_cnt_nxt = mdu_cnt_q - CNT_ONE;
      end
    end else if (mispredict) begin
      // ID holds a wrong-path instruction, so any load-use against it is irrelevant.
      o_PC_Redirect = 1'b1;
      o_IFID_Flush  = 1'b1;
      o_IDEX_Flush  = 1'b1;
    end else if (i_MDU_Start) begin
      o_PC_Stall    = 1'b1;
      o_IFID_Stall  = 1'b1;
      o_IDEX_Stall  = 1'b1;
      o_EXMEM_Flush = 1'b1;
      if (MDU_LATENCY > 1) begin
        state_nxt   = S_MDU;
        mdu_cnt_nxt = MDU_CNT_INIT;
      end
    end else if (loaduse) begin
      // One bubble is enough: the load moves on to MEM next cycle.
      o_PC_Stall   = 1'b1;
      o_IFID_Stall = 1'b1;
      o_IDEX_Flush = 1'b1;
    end
  end

  // FSM state and MDU countdown registers.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= S_RUN;
      mdu_cnt_q <= '0;
    end else begin
      state_q   <= state_nxt;
      mdu_cnt_q <= mdu_cnt_nxt;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] mp_cnt_q;
  logic [31:0] stall_cnt_q;

  // Wrapping perf counters; redirect only ever fires on an acted-on mispredict.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      mp_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (o_PC_Redirect) mp_cnt_q <= mp_cnt_q + 32'd1;
      if (o_PC_Stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_Mispredict_Count = mp_cnt_q;
  assign o_Stall_Cycles     = stall_cnt_q;
`else
  assign o_Mispredict_Count = '0;
  assign o_Stall_Cycles     = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table vectors, hand-written multi-cycle sequences, randomized model compare.
// Two instances share the stimulus: MDU_LATENCY=8 and MDU_LATENCY=1.
// Outputs sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       memread;
    logic [4:0] ex_rt;
    logic       bv;
    logic       bt;
    logic       pred;
    logic       start;
    logic       busy;
  } in_t;

  typedef struct {
    in_t        vin;
    logic [7:0] exp;
  } vec_t;

  // Output vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, exmem_flush, redirect}
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_BUSY = 8'b1101_0100;
  localparam logic [7:0] O_MDU  = 8'b1101_0010;
  localparam logic [7:0] O_MISP = 8'b0010_1001;
  localparam logic [7:0] O_LU   = 8'b1100_1000;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  in_t  vin = '0;

  always #5 clk = ~clk;

  logic pcs8, ifs8, iff8, ids8, idf8, exs8, exf8, rd8;
  logic pcs1, ifs1, iff1, ids1, idf1, exs1, exf1, rd1;
  logic [31:0] mcnt8, scnt8, mcnt1, scnt1;
  logic [7:0]  out8, out1;

  assign out8 = {pcs8, ifs8, iff8, ids8, idf8, exs8, exf8, rd8};
  assign out1 = {pcs1, ifs1, iff1, ids1, idf1, exs1, exf1, rd1};

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MDU_LATENCY(8), .CNT_WIDTH(8)) dut (
    .i_Clk(clk), .i_Reset(rst),
    .i_ID_Rs(vin.rs), .i_ID_Rt(vin.rt), .i_ID_Uses_Rt(vin.uses_rt),
    .i_EX_MemRead(vin.memread), .i_EX_Rt(vin.ex_rt),
    .i_EX_Branch_Valid(vin.bv), .i_EX_Branch_Taken(vin.bt), .i_EX_Prediction(vin.pred),
    .i_MDU_Start(vin.start), .i_Mem_Busy(vin.busy),
    .o_PC_Stall(pcs8), .o_IFID_Stall(ifs8), .o_IFID_Flush(iff8),
    .o_IDEX_Stall(ids8), .o_IDEX_Flush(idf8), .o_EXMEM_Stall(exs8), .o_EXMEM_Flush(exf8),
    .o_PC_Redirect(rd8), .o_Mispredict_Count(mcnt8), .o_Stall_Cycles(scnt8)
  );

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MDU_LATENCY(1), .CNT_WIDTH(8)) dut1 (
    .i_Clk(clk), .i_Reset(rst),
    .i_ID_Rs(vin.rs), .i_ID_Rt(vin.rt), .i_ID_Uses_Rt(vin.uses_rt),
    .i_EX_MemRead(vin.memread), .i_EX_Rt(vin.ex_rt),
    .i_EX_Branch_Valid(vin.bv), .i_EX_Branch_Taken(vin.bt), .i_EX_Prediction(vin.pred),
    .i_MDU_Start(vin.start), .i_Mem_Busy(vin.busy),
    .o_PC_Stall(pcs1), .o_IFID_Stall(ifs1), .o_IFID_Flush(iff1),
    .o_IDEX_Stall(ids1), .o_IDEX_Flush(idf1), .o_EXMEM_Stall(exs1), .o_EXMEM_Flush(exf1),
    .o_PC_Redirect(rd1), .o_Mispredict_Count(mcnt1), .o_Stall_Cycles(scnt1)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: number of MDU stall cycles still owed, plus perf counts.
  int          r8 = 0;
  int          r1 = 0;
  logic [31:0] mc8 = '0, sc8 = '0, mc1 = '0, sc1 = '0;
  logic [7:0]  obs8, obs1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Hazard rules evaluated on the current inputs for an MDU of latency L with r cycles still owed.
  task automatic model(input int L, input int r, output logic [7:0] o, output int rn, output bit mp);
    bit mis, lu;
    mis = vin.bv && (vin.bt != vin.pred);
    lu  = vin.memread && (vin.ex_rt != 0) &&
          ((vin.ex_rt == vin.rs) || (vin.uses_rt && vin.ex_rt == vin.rt));
    o = O_NONE; rn = r; mp = 1'b0;
    if (rst)            begin o = O_NONE; rn = 0; end
    else if (vin.busy)  o = O_BUSY;
    else if (r > 0)     begin o = O_MDU; rn = r - 1; end
    else if (mis)       begin o = O_MISP; mp = 1'b1; end
    else if (vin.start) begin o = O_MDU; rn = L - 1; end
    else if (lu)        o = O_LU;
  endtask

  // One clock: compare both DUTs to the model at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic [7:0] e8, e1;
    int rn8, rn1;
    bit mp8, mp1;
    @(negedge clk);
    model(8, r8, e8, rn8, mp8);
    model(1, r1, e1, rn1, mp1);
    obs8 = out8;
    obs1 = out1;
    check("model_lat8", {24'd0, out8}, {24'd0, e8});
    check("model_lat1", {24'd0, out1}, {24'd0, e1});
    check("mpcnt_lat8", mcnt8, PERF ? mc8 : 32'd0);
    check("stcnt_lat8", scnt8, PERF ? sc8 : 32'd0);
    check("mpcnt_lat1", mcnt1, PERF ? mc1 : 32'd0);
    check("stcnt_lat1", scnt1, PERF ? sc1 : 32'd0);
    @(posedge clk);
    r8 = rn8;
    r1 = rn1;
    if (rst) begin
      mc8 = '0; sc8 = '0; mc1 = '0; sc1 = '0;
    end else begin
      mc8 = mc8 + 32'(mp8); sc8 = sc8 + 32'(e8[7]);
      mc1 = mc1 + 32'(mp1); sc1 = sc1 + 32'(e1[7]);
    end
    #1;
  endtask

  function automatic in_t mk(input int rs, input int rt, input bit uses, input bit mr, input int exrt,
                             input bit bv, input bit bt, input bit pred, input bit busy);
    in_t v;
    v = '0;
    v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = uses; v.memread = mr; v.ex_rt = 5'(exrt);
    v.bv = bv; v.bt = bt; v.pred = pred; v.busy = busy;
    return v;
  endfunction

  initial begin
    vec_t tbl[14];
    int   n_mdu, n_mdu1, n_busy, n_zero;

    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), O_NONE};
    tbl[1]  = '{mk(5, 0, 0, 1, 5, 0, 0, 0, 0), O_LU};
    tbl[2]  = '{mk(2, 5, 1, 1, 5, 0, 0, 0, 0), O_LU};
    tbl[3]  = '{mk(2, 5, 0, 1, 5, 0, 0, 0, 0), O_NONE};
    tbl[4]  = '{mk(0, 0, 1, 1, 0, 0, 0, 0, 0), O_NONE};
    tbl[5]  = '{mk(5, 0, 0, 0, 5, 0, 0, 0, 0), O_NONE};
    tbl[6]  = '{mk(5, 0, 0, 1, 5, 1, 1, 0, 0), O_MISP};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 1, 0, 1, 0), O_MISP};
    tbl[8]  = '{mk(5, 0, 0, 1, 5, 1, 1, 1, 0), O_LU};
    tbl[9]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0), O_NONE};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1), O_BUSY};
    tbl[11] = '{mk(0, 0, 0, 0, 0, 1, 1, 0, 1), O_BUSY};
    tbl[12] = '{mk(5, 0, 0, 1, 5, 0, 0, 0, 1), O_BUSY};
    tbl[13] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), O_NONE};

    // Settle flops under reset before any comparison.
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_outputs", {24'd0, obs8}, 32'd0);
    end
    rst = 1'b0;

    // Single-cycle combinational cases from S_RUN.
    for (int i = 0; i < 14; i++) begin
      vin = tbl[i].vin;
      step();
      check($sformatf("table%0d", i), {24'd0, obs8}, {24'd0, tbl[i].exp});
      check($sformatf("table%0d_lat1", i), {24'd0, obs1}, {24'd0, tbl[i].exp});
    end

    // MDU pulse: stall window length for both latencies.
    n_mdu = 0; n_mdu1 = 0; n_zero = 0;
    for (int i = 0; i < 12; i++) begin
      vin = '0;
      vin.start = (i == 0);
      step();
      if (obs8 == O_MDU) n_mdu++;
      if (obs8 == O_NONE) n_zero++;
      if (obs1 == O_MDU) n_mdu1++;
    end
    check("mdu_len_lat8", n_mdu, 8);
    check("mdu_idle_lat8", n_zero, 4);
    check("mdu_len_lat1", n_mdu1, 1);

    // Mem busy for 3 cycles starting at MDU stall cycle 4 stretches the window to 11.
    n_mdu = 0; n_busy = 0; n_zero = 0;
    for (int i = 0; i < 16; i++) begin
      vin = '0;
      vin.start = (i == 0);
      vin.busy  = (i >= 3 && i < 6);
      step();
      if (obs8 == O_MDU) n_mdu++;
      if (obs8 == O_BUSY) n_busy++;
      if (obs8 == O_NONE && i < 11) n_zero++;
    end
    check("mdu_busy_mdu_cycles", n_mdu, 8);
    check("mdu_busy_busy_cycles", n_busy, 3);
    check("mdu_busy_window_gap", n_zero, 0);

    // Reset while in S_MDU with the countdown at 3.
    vin = '0; vin.start = 1'b1;
    step();
    vin = '0;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_mid_mdu", {24'd0, obs8}, 32'd0);
    end
    rst = 1'b0;
    step();
    check("after_reset_idle", {24'd0, obs8}, 32'd0);

    // Mispredict held during busy; acted on when busy drops.
    vin = mk(0, 0, 0, 0, 0, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("busy_hides_redirect", {24'd0, obs8}, {24'd0, O_BUSY});
    end
    vin.busy = 1'b0;
    step();
    check("redirect_after_busy", {24'd0, obs8}, {24'd0, O_MISP});
    vin = '0;
    step();
    check("perf_mispredicts", mcnt8, PERF ? 32'd1 : 32'd0);
    check("perf_stall_cycles", scnt8, PERF ? 32'd3 : 32'd0);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      vin.rs      = 5'($urandom_range(0, 3));
      vin.rt      = 5'($urandom_range(0, 3));
      vin.uses_rt = 1'($urandom_range(0, 1));
      vin.memread = 1'($urandom_range(0, 1));
      vin.ex_rt   = 5'($urandom_range(0, 3));
      vin.bv      = ($urandom_range(0, 2) == 0);
      vin.bt      = 1'($urandom_range(0, 1));
      vin.pred    = 1'($urandom_range(0, 1));
      vin.start   = ($urandom_range(0, 9) == 0);
      vin.busy    = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
